// File: rtl/go_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : go_pkg
// Description : Shared types, constants and helpers for the Go move controller.
//               Cell and state encodings, board shape, cursor reset position.
// Revision    : 1.0 - initial release
// ============================================================================
package go_pkg;

  localparam int          BOARD_N      = 9;
  localparam logic [7:0]  CURSOR_RESET = 8'h44;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10,
    RED   = 2'b11
  } cell_t;

  // board[row][col], each cell two bits wide
  typedef logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    WAIT_VBL  = 3'd2,
    FLASH_ARM = 3'd3,
    FLASH     = 3'd4,
    OVER      = 3'd5
  } state_t;

  // Move counter never rolls over: 255 stays 255
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Move counter never goes below zero
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction

  // Coordinate step with wrap across the 0..BOARD_N-1 range
  function automatic logic [3:0] wrap_inc(input logic [3:0] v);
    return (v == 4'(BOARD_N - 1)) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [3:0] wrap_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'(BOARD_N - 1) : v - 4'd1;
  endfunction

endpackage : go_pkg
`default_nettype wire

// File: rtl/go_move_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Interface   : go_move_ctrl_if
// Description : Button/frame inputs and board/status outputs of go_move_ctrl.
//               master = button/frame source, slave = the controller.
//               Optional macro GO_UNDO_EN adds the btn_undo signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface go_move_ctrl_if;
  import go_pkg::*;

  logic       frame_start;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_place;
  logic       btn_pass;
  logic       btn_new;
`ifdef GO_UNDO_EN
  logic       btn_undo;
`endif
  board_t     board;
  logic [7:0] cursor_pos;
  logic       turn;
  logic       game_over;
  logic       busy;
  logic [7:0] move_count;

  modport master (
`ifdef GO_UNDO_EN
    output btn_undo,
`endif
    output frame_start, btn_up, btn_down, btn_left, btn_right,
    output btn_place, btn_pass, btn_new,
    input  board, cursor_pos, turn, game_over, busy, move_count
  );

  modport slave (
`ifdef GO_UNDO_EN
    input  btn_undo,
`endif
    input  frame_start, btn_up, btn_down, btn_left, btn_right,
    input  btn_place, btn_pass, btn_new,
    output board, cursor_pos, turn, game_over, busy, move_count
  );

endinterface : go_move_ctrl_if
`default_nettype wire

// File: rtl/go_cursor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : go_cursor
// Description : Cursor row/col registers with wrap-around moves. Moves are
//               only taken while en is high; up > down > left > right.
// Revision    : 1.0 - initial release
// ============================================================================
module go_cursor
  import go_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic       clr,
  input  wire logic       en,
  input  wire logic       up,
  input  wire logic       down,
  input  wire logic       left,
  input  wire logic       right,
  output logic [7:0]      cursor_pos
);

  logic [3:0] r_row;
  logic [3:0] r_col;

  // Cursor position register: reset/new-game recentre, else one move per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row <= CURSOR_RESET[7:4];
      r_col <= CURSOR_RESET[3:0];
    end else if (clr) begin
      r_row <= CURSOR_RESET[7:4];
      r_col <= CURSOR_RESET[3:0];
    end else if (en) begin
      if (up)         r_row <= wrap_dec(r_row);
      else if (down)  r_row <= wrap_inc(r_row);
      else if (left)  r_col <= wrap_dec(r_col);
      else if (right) r_col <= wrap_inc(r_col);
    end
  end

  assign cursor_pos = {r_row, r_col};

endmodule : go_cursor
`default_nettype wire

// File: rtl/go_move_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : go_move_ctrl
// Description : Sequences cursor moves, stone placement, passes and the red
//               illegal-move marker for a 9x9 Go board. Board writes happen
//               only on frame_start so the renderer never sees a torn board.
//               Optional macro GO_UNDO_EN enables one-level undo.
// Revision    : 1.0 - initial release
// ============================================================================
module go_move_ctrl
  import go_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter bit START_WHITE  = 1'b0
) (
  input  wire logic    clk,
  input  wire logic    reset_n,
  go_move_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  state_t           r_state;
  board_t           r_board;
  logic             r_turn;
  logic             r_game_over;
  logic [7:0]       r_move_count;
  logic [1:0]       r_pass_cnt;
  logic [3:0]       r_tgt_row;
  logic [3:0]       r_tgt_col;
  logic [1:0]       r_saved;
  logic [CNT_W-1:0] r_flash_cnt;
`ifdef GO_UNDO_EN
  logic [3:0]       r_last_row;
  logic [3:0]       r_last_col;
  logic             r_last_valid;
  logic             r_undo;
`endif

  logic [7:0] w_cursor_pos;
  logic       w_cur_en;
  logic       w_hi_prio;

  // Any higher-priority button in IDLE suppresses cursor motion that cycle
`ifdef GO_UNDO_EN
  assign w_hi_prio = bus.btn_new | bus.btn_place | bus.btn_pass | bus.btn_undo;
`else
  assign w_hi_prio = bus.btn_new | bus.btn_place | bus.btn_pass;
`endif
  assign w_cur_en = (r_state == IDLE) && !w_hi_prio;

  go_cursor u_cursor (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (bus.btn_new),
    .en         (w_cur_en),
    .up         (bus.btn_up),
    .down       (bus.btn_down),
    .left       (bus.btn_left),
    .right      (bus.btn_right),
    .cursor_pos (w_cursor_pos)
  );

  // Main game FSM: owns board, turn, pass/move counters and flash timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_board      <= '0;
      r_turn       <= START_WHITE;
      r_game_over  <= 1'b0;
      r_move_count <= 8'd0;
      r_pass_cnt   <= 2'd0;
      r_tgt_row    <= 4'd0;
      r_tgt_col    <= 4'd0;
      r_saved      <= EMPTY;
      r_flash_cnt  <= '0;
`ifdef GO_UNDO_EN
      r_last_row   <= 4'd0;
      r_last_col   <= 4'd0;
      r_last_valid <= 1'b0;
      r_undo       <= 1'b0;
`endif
    end else if (bus.btn_new) begin
      r_state      <= IDLE;
      r_board      <= '0;
      r_turn       <= START_WHITE;
      r_game_over  <= 1'b0;
      r_move_count <= 8'd0;
      r_pass_cnt   <= 2'd0;
      r_tgt_row    <= 4'd0;
      r_tgt_col    <= 4'd0;
      r_saved      <= EMPTY;
      r_flash_cnt  <= '0;
`ifdef GO_UNDO_EN
      r_last_row   <= 4'd0;
      r_last_col   <= 4'd0;
      r_last_valid <= 1'b0;
      r_undo       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.btn_place) begin
            // Latch the target now; later cursor motion cannot retarget it
            r_tgt_row <= w_cursor_pos[7:4];
            r_tgt_col <= w_cursor_pos[3:0];
            r_state   <= CHECK;
          end
`ifdef GO_UNDO_EN
          else if (bus.btn_undo) begin
            if (r_last_valid) begin
              r_tgt_row <= r_last_row;
              r_tgt_col <= r_last_col;
              r_undo    <= 1'b1;
              r_state   <= WAIT_VBL;
            end
          end
`endif
          else if (bus.btn_pass) begin
            r_turn       <= ~r_turn;
            r_move_count <= sat_inc(r_move_count);
            r_pass_cnt   <= r_pass_cnt + 2'd1;
`ifdef GO_UNDO_EN
            r_last_valid <= 1'b0;
`endif
            if (r_pass_cnt == 2'd1) begin
              r_game_over <= 1'b1;
              r_state     <= OVER;
            end
          end
        end

        CHECK: begin
          if (r_board[r_tgt_row][r_tgt_col] == EMPTY) begin
            r_state <= WAIT_VBL;
          end else begin
            r_saved <= r_board[r_tgt_row][r_tgt_col];
            r_state <= FLASH_ARM;
          end
        end

        WAIT_VBL: begin
          if (bus.frame_start) begin
            r_turn  <= ~r_turn;
            r_state <= IDLE;
`ifdef GO_UNDO_EN
            if (r_undo) begin
              r_board[r_tgt_row][r_tgt_col] <= EMPTY;
              r_move_count <= sat_dec(r_move_count);
              r_last_valid <= 1'b0;
              r_undo       <= 1'b0;
            end else begin
              r_board[r_tgt_row][r_tgt_col] <= r_turn ? WHITE : BLACK;
              r_move_count <= sat_inc(r_move_count);
              r_pass_cnt   <= 2'd0;
              r_last_row   <= r_tgt_row;
              r_last_col   <= r_tgt_col;
              r_last_valid <= 1'b1;
            end
`else
            r_board[r_tgt_row][r_tgt_col] <= r_turn ? WHITE : BLACK;
            r_move_count <= sat_inc(r_move_count);
            r_pass_cnt   <= 2'd0;
`endif
          end
        end

        FLASH_ARM: begin
          if (bus.frame_start) begin
            r_board[r_tgt_row][r_tgt_col] <= RED;
            r_flash_cnt <= CNT_W'(FLASH_FRAMES);
            r_state     <= FLASH;
          end
        end

        FLASH: begin
          if (bus.frame_start) begin
            r_flash_cnt <= r_flash_cnt - CNT_W'(1);
            // The frame that takes the timer to zero puts the old stone back
            if (r_flash_cnt == CNT_W'(1)) begin
              r_board[r_tgt_row][r_tgt_col] <= r_saved;
              r_state <= IDLE;
            end
          end
        end

        OVER: begin
`ifdef GO_UNDO_EN
          if (bus.btn_undo) begin
            r_game_over <= 1'b0;
            r_pass_cnt  <= 2'd1;
            r_state     <= IDLE;
          end
`endif
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.board      = r_board;
  assign bus.cursor_pos = w_cursor_pos;
  assign bus.turn       = r_turn;
  assign bus.game_over  = r_game_over;
  assign bus.busy       = (r_state != IDLE);
  assign bus.move_count = r_move_count;

endmodule : go_move_ctrl
`default_nettype wire
